// File: rtl/l2_promotion_ctrl_pkg.sv
// Shared L2 configuration: FSM encoding, default geometry and address-split helpers.
package l2_promotion_ctrl_pkg;

  localparam int L2_NUM_SETS = 64;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOOKUP  = 3'd1,
    ST_MEM_REQ = 3'd2,
    ST_FILL    = 3'd3,
    ST_PROMOTE = 3'd4
  } l2_state_e;

  function automatic int compute_index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int compute_tag_bits(input int addr_w, input int num_sets);
    return addr_w - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/l2_promotion_ctrl_tag_store.sv
// Direct-mapped L2 line store: valid/tag/data arrays, registered read port, one write port,
// flush-all and asynchronous valid clear.
module l2_promotion_ctrl_tag_store #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 5,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  rd_en,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int NUM_SETS = 1 << INDEX_BITS;

  logic [NUM_SETS-1:0] valid;
  logic [TAG_BITS-1:0] tags  [NUM_SETS];
  logic [DATA_W-1:0]   words [NUM_SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  // Read stage: the looked-up line is presented one cycle after rd_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_valid <= valid[rd_index];
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_tag  <= tags[rd_index];
      rd_data <= words[rd_index];
    end
  end

endmodule

// File: rtl/l2_promotion_ctrl.sv
// L2 responder for L1 misses: direct-mapped lookup, memory fetch and fill on miss,
// one-cycle promotion pulse back to L1, saturating hit/miss statistics.
module l2_promotion_ctrl
  import l2_promotion_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 32,
  parameter int NUM_SETS = L2_NUM_SETS,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              busy,
  input  logic              flush,
  output logic              promote_data,
  output logic [DATA_W-1:0] promotion_data,
  output logic [ADDR_W-1:0] promote_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  l2_hit_cnt,
  output logic [CNT_W-1:0]  l2_miss_cnt
);

  localparam int INDEX_BITS = compute_index_bits(NUM_SETS);
  localparam int TAG_BITS   = compute_tag_bits(ADDR_W, NUM_SETS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  l2_state_e state, state_next;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   word_q;
  logic [TAG_BITS-1:0] addr_tag;
  logic                rd_valid;
  logic [TAG_BITS-1:0] rd_tag;
  logic [DATA_W-1:0]   rd_data;
  logic                lookup_hit;
  logic                flush_en;

  assign addr_tag   = addr_q[ADDR_W-1:INDEX_BITS];
  assign lookup_hit = rd_valid && (rd_tag == addr_tag);
  assign flush_en   = (state == ST_IDLE) && !req_valid && flush;

  assign busy         = (state != ST_IDLE);
  assign promote_data = (state == ST_PROMOTE);
  assign mem_req      = (state == ST_MEM_REQ);

  // The read is issued straight from req_addr so the line is ready during LOOKUP.
  l2_promotion_ctrl_tag_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .DATA_W     (DATA_W)
  ) u_store (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush_en),
    .rd_en    (state == ST_IDLE),
    .rd_index (req_addr[INDEX_BITS-1:0]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (state == ST_FILL),
    .wr_index (addr_q[INDEX_BITS-1:0]),
    .wr_tag   (addr_tag),
    .wr_data  (word_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Hits also pass through FILL: rewriting a line with its own contents is a no-op and
  // gives hits their two-cycle promotion latency while sharing the FILL->PROMOTE path.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (req_valid) state_next = ST_LOOKUP;
      ST_LOOKUP:  state_next = lookup_hit ? ST_FILL : ST_MEM_REQ;
      ST_MEM_REQ: if (mem_ack) state_next = ST_FILL;
      ST_FILL:    state_next = ST_PROMOTE;
      ST_PROMOTE: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      addr_q <= req_addr;
    end
    if (state == ST_LOOKUP && lookup_hit) begin
      word_q <= rd_data;
    end else if (state == ST_MEM_REQ && mem_ack) begin
      word_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr       <= '0;
      promotion_data <= '0;
      promote_addr   <= '0;
      l2_hit_cnt     <= '0;
      l2_miss_cnt    <= '0;
    end else begin
      if (state == ST_LOOKUP) begin
        if (lookup_hit) begin
          l2_hit_cnt <= sat_inc(l2_hit_cnt);
        end else begin
          l2_miss_cnt <= sat_inc(l2_miss_cnt);
          mem_addr    <= addr_q;
        end
      end
      if (state == ST_FILL) begin
        promotion_data <= word_q;
        promote_addr   <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_l2_promotion_ctrl.sv
// Scoreboard bench for l2_promotion_ctrl: directed scenarios plus randomized traffic
// against a line-level cache model; CNT_W=4 so counter saturation is reached.
module tb_l2_promotion_ctrl;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 32;
  localparam int NUM_SETS = 64;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              busy;
  logic              flush = 1'b0;
  logic              promote_data;
  logic [DATA_W-1:0] promotion_data;
  logic [ADDR_W-1:0] promote_addr;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [CNT_W-1:0]  l2_hit_cnt;
  logic [CNT_W-1:0]  l2_miss_cnt;

  l2_promotion_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SETS(NUM_SETS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr), .busy(busy),
    .flush(flush), .promote_data(promote_data), .promotion_data(promotion_data),
    .promote_addr(promote_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .l2_hit_cnt(l2_hit_cnt),
    .l2_miss_cnt(l2_miss_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: each set remembers which full address it holds and that word.
  bit                m_valid [NUM_SETS];
  logic [ADDR_W-1:0] m_addr  [NUM_SETS];
  logic [DATA_W-1:0] m_data  [NUM_SETS];
  int                m_hits = 0;
  int                m_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_SETS; i++) m_valid[i] = 1'b0;
  endtask

  logic prev_promote = 1'b0;

  always @(negedge clk) begin
    if (rst_n && promote_data) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_promote: got addr 0x%0h data 0x%0h, want no promotion",
                 promote_addr, promotion_data);
      end else begin
        mon_e = sbq.pop_front();
        check("promotion_data", promotion_data, mon_e.data);
        check("promote_addr", 32'(promote_addr), 32'(mon_e.addr));
        check("promote_cycle", cyc, mon_e.cyc);
      end
    end
    if (rst_n && prev_promote) begin
      check("promote_pulse_width", 32'(promote_data), 32'd0);
      check("busy_after_promote", 32'(busy), 32'd0);
    end
    prev_promote <= rst_n && promote_data;
  end

  // Caller is at a falling edge; returns at a falling edge with the DUT idle.
  task automatic do_req(input logic [ADDR_W-1:0] a, input int dly, input bit hold,
                        input bit flush_mid, input logic [DATA_W-1:0] d);
    int  c0, k, idx;
    bit  hit, ok, saw_req;
    idx = int'(a) % NUM_SETS;
    hit = m_valid[idx] && (m_addr[idx] == a);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk); #1;
    c0 = cyc;
    req_valid = hold && !hit;
    if (hit) begin
      m_hits = (m_hits < CNT_MAX) ? m_hits + 1 : m_hits;
      sbq.push_back('{a, m_data[idx], c0 + 2});
    end else begin
      m_miss = (m_miss < CNT_MAX) ? m_miss + 1 : m_miss;
      if (flush_mid) flush = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
        @(negedge clk);
        ok = mem_req;
      end
      if (!ok) begin
        fail_now("mem_req_timeout");
        req_valid = 1'b0;
        flush     = 1'b0;
      end else begin
        check("mem_req_cycle", cyc, c0 + 1);
        check("mem_addr", 32'(mem_addr), 32'(a));
        for (int i = 0; i < dly; i++) begin
          @(negedge clk);
          check("mem_req_held", 32'(mem_req), 32'd1);
          check("mem_addr_stable", 32'(mem_addr), 32'(a));
        end
        mem_ack   = 1'b1;
        mem_rdata = d;
        @(posedge clk); #1;
        k = cyc;
        mem_ack   = 1'b0;
        req_valid = 1'b0;
        flush     = 1'b0;
        m_valid[idx] = 1'b1;
        m_addr[idx]  = a;
        m_data[idx]  = d;
        sbq.push_back('{a, d, k + 1});
        @(negedge clk);
        check("mem_req_drop", 32'(mem_req), 32'd0);
      end
    end
    ok = 1'b0;
    saw_req = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      @(negedge clk);
      saw_req = saw_req || mem_req;
      ok = !busy;
    end
    if (!ok) fail_now("idle_timeout");
    if (hit) check("hit_no_mem_req", 32'(saw_req), 32'd0);
    check("pending_promotions", sbq.size(), 0);
    sbq.delete();
    check("l2_hit_cnt", 32'(l2_hit_cnt), m_hits);
    check("l2_miss_cnt", 32'(l2_miss_cnt), m_miss);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    @(negedge clk);
    check("busy_after_flush", 32'(busy), 32'd0);
  endtask

  initial begin
    bit ok;
    model_clear();
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_promote_data", 32'(promote_data), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_promotion_data", promotion_data, 32'd0);
    check("rst_promote_addr", 32'(promote_addr), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_hit_cnt", 32'(l2_hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(l2_miss_cnt), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(11'h123, 1, 1'b0, 1'b0, 32'hDEADBEEF);
    do_req(11'h123, 0, 1'b0, 1'b0, 32'h0);
    do_req(11'h163, 0, 1'b0, 1'b0, 32'h11112222);
    do_req(11'h123, 2, 1'b0, 1'b0, $urandom);
    do_req(11'h1A7, 3, 1'b1, 1'b1, $urandom);
    do_req(11'h1A7, 0, 1'b0, 1'b0, 32'h0);
    do_flush();
    do_req(11'h163, 1, 1'b0, 1'b0, $urandom);
    for (int i = 0; i < 16; i++) do_req(11'h163, 0, 1'b0, 1'b0, 32'h0);

    req_valid = 1'b1;
    req_addr  = 11'h2F5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = mem_req;
    end
    if (!ok) fail_now("reset_test_mem_req");
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_hit_cnt", 32'(l2_hit_cnt), 32'd0);
    check("midrst_miss_cnt", 32'(l2_miss_cnt), 32'd0);
    model_clear();
    m_hits = 0;
    m_miss = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_mem_req", 32'(mem_req), 32'd0);
      check("late_ack_busy", 32'(busy), 32'd0);
    end
    do_req(11'h163, 0, 1'b0, 1'b0, $urandom);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(9) == 0) begin
        do_flush();
      end else begin
        do_req(ADDR_W'(($urandom_range(3) << 6) | $urandom_range(7)), $urandom_range(3),
               1'b0, 1'b0, $urandom);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
